// File: rtl/mem_responder.sv
// Single-ported word memory answering a CPU's split fetch and data ports.
// Round-robin arbitration between ports, fixed grant-to-resp latency.
module mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        imem_read,
  output logic [31:0] instr,
  output logic        imem_resp,
  input  logic [31:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_rdata,
  output logic        mem_resp
);

  // state | meaning
  // IDLE  | no transaction; arbitrate and grant pending port
  // BUSY  | counting latency for the granted port
  // RESP  | one-cycle completion pulse on the granted port
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int DEPTH = 1 << ADDR_BITS;

  state_t                 state;
  logic [3:0]             cnt;
  logic                   prefer_data;
  logic                   grant_is_data;
  logic [31:0]            mem [DEPTH];

  logic [ADDR_BITS-1:0]   d_idx;
  logic [ADDR_BITS-1:0]   f_idx;
  logic                   data_pending;
  logic                   grant;
  logic                   grant_data;
  logic                   grant_write;
  logic                   unused_addr_bits;

  assign d_idx        = mem_address[ADDR_BITS+1:2];
  assign f_idx        = pc[ADDR_BITS+1:2];
  assign data_pending = mem_read | mem_write;
  assign grant        = (state == IDLE) && (data_pending || imem_read);
  assign grant_data   = data_pending && (!imem_read || prefer_data);
  assign grant_write  = grant && grant_data && mem_write;

  assign unused_addr_bits = ^{pc[31:ADDR_BITS+2], pc[1:0],
                              mem_address[31:ADDR_BITS+2], mem_address[1:0]};

  // Array has no reset: contents survive rst, and a granted write is committed at once.
  always_ff @(posedge clk) begin
    if (grant_write && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_byte_enable[i]) mem[d_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      prefer_data   <= 1'b1;
      grant_is_data <= 1'b0;
      imem_resp     <= 1'b0;
      mem_resp      <= 1'b0;
      instr         <= '0;
      mem_rdata     <= '0;
    end else begin
      imem_resp <= 1'b0;
      mem_resp  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            grant_is_data <= grant_data;
            prefer_data   <= !grant_data;
            if (grant_data) begin
              if (!mem_write) mem_rdata <= mem[d_idx];
            end else begin
              instr <= mem[f_idx];
            end
            if (LATENCY == 1) begin
              state <= RESP;
              if (grant_data) mem_resp <= 1'b1;
              else            imem_resp <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= '0;
            if (grant_is_data) mem_resp <= 1'b1;
            else               imem_resp <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: randomized transactions against a word-array model;
// a second instance with LATENCY=1 exercises continuous fetch throughput.
module tb_mem_responder;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0, mem_address = '0, mem_wdata = '0;
  logic        imem_read = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [3:0]  mem_byte_enable = '0;
  logic [31:0] instr, mem_rdata;
  logic        imem_resp, mem_resp;

  logic [31:0] f_pc = '0, f_mem_address = '0, f_mem_wdata = '0;
  logic        f_imem_read = 1'b0, f_mem_read = 1'b0, f_mem_write = 1'b0;
  logic [3:0]  f_mem_byte_enable = '0;
  logic [31:0] f_instr, f_mem_rdata;
  logic        f_imem_resp, f_mem_resp;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(10), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .pc(pc), .imem_read(imem_read), .instr(instr),
    .imem_resp(imem_resp), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp));

  mem_responder #(.ADDR_BITS(10), .LATENCY(1)) dut_fast (
    .clk(clk), .rst(rst), .pc(f_pc), .imem_read(f_imem_read), .instr(f_instr),
    .imem_resp(f_imem_resp), .mem_address(f_mem_address), .mem_read(f_mem_read),
    .mem_write(f_mem_write), .mem_wdata(f_mem_wdata), .mem_byte_enable(f_mem_byte_enable),
    .mem_rdata(f_mem_rdata), .mem_resp(f_mem_resp));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] exp;
    int          issue;
    int          lat;
  } ent_t;

  ent_t        dq[$];
  ent_t        fq[$];
  logic [31:0] model [1024];
  bit          prefer_data = 1'b1;
  logic [31:0] last_rdata = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  function automatic ent_t model_data(bit wr, logic [31:0] a, logic [31:0] wd, logic [3:0] be);
    ent_t e;
    int   i = widx(a);
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model[i][8*b +: 8] = wd[8*b +: 8];
      e.exp = last_rdata;
    end else begin
      last_rdata = model[i];
      e.exp = model[i];
    end
    return e;
  endfunction

  function automatic ent_t model_fetch(logic [31:0] a);
    ent_t e;
    e.exp = model[widx(a)];
    return e;
  endfunction

  // Scoreboard monitor: every resp pulse pops the oldest expectation for that port.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_resp && mem_resp) begin
        checks++; failures++;
        $display("FAIL both_resp actual=11 required=not both");
      end
      if (mem_resp) begin
        if (dq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_mem_resp actual=1 required=0");
        end else begin
          ent_t e;
          e = dq.pop_front();
          chk("mem_rdata", mem_rdata, e.exp);
          chk("mem_latency", 32'(cyc - e.issue), 32'(e.lat));
        end
      end
      if (imem_resp) begin
        if (fq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_imem_resp actual=1 required=0");
        end else begin
          ent_t e;
          e = fq.pop_front();
          chk("instr", instr, e.exp);
          chk("imem_latency", 32'(cyc - e.issue), 32'(e.lat));
        end
      end
    end
  end

  task automatic txn(input bit dd, input bit dw, input bit dr, input logic [31:0] da,
                     input logic [31:0] wd, input logic [3:0] be,
                     input bit df, input logic [31:0] fa);
    ent_t de, fe;
    bit   data_first, dpend, fpend;
    @(negedge clk);
    data_first = dd && (!df || prefer_data);
    if (data_first) begin
      de = model_data(dw, da, wd, be); de.lat = L;
      if (df) begin fe = model_fetch(fa); fe.lat = 2*L + 1; end
      prefer_data = df;
    end else begin
      if (df) begin fe = model_fetch(fa); fe.lat = L; end
      if (dd) begin de = model_data(dw, da, wd, be); de.lat = 2*L + 1; end
      prefer_data = !dd;
    end
    de.issue = cyc; fe.issue = cyc;
    if (dd) dq.push_back(de);
    if (df) fq.push_back(fe);
    mem_read = dd & dr; mem_write = dd & dw; mem_address = da;
    mem_wdata = wd; mem_byte_enable = be;
    imem_read = df; pc = fa;
    dpend = dd; fpend = df;
    for (int n = 0; n < 8*L + 20 && (dpend || fpend); n++) begin
      @(negedge clk);
      if (dpend && mem_resp) begin dpend = 0; mem_read = 0; mem_write = 0; end
      if (fpend && imem_resp) begin fpend = 0; imem_read = 0; end
    end
    if (dpend || fpend) begin
      checks++; failures++;
      $display("FAIL txn_timeout actual=no resp required=resp within budget");
      mem_read = 0; mem_write = 0; imem_read = 0;
      dq.delete(); fq.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_read = 0; mem_write = 0; imem_read = 0;
    @(negedge clk);
    chk("rst_instr", instr, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_imem_resp", {31'b0, imem_resp}, 32'h0);
    chk("rst_mem_resp", {31'b0, mem_resp}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    prefer_data = 1'b1;
    last_rdata = '0;
    dq.delete(); fq.delete();
  endtask

  initial begin
    logic [31:0] fw [8];
    bit          seen;
    int          k, last;
    bit          done;

    do_reset();
    for (int i = 0; i < 16; i++) txn(1, 1, 0, 32'(i*4), $urandom, 4'hF, 0, 0);

    txn(1, 1, 0, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0);
    txn(1, 0, 1, 32'h100, 0, 4'h0, 0, 0);
    txn(1, 1, 0, 32'h200, 32'h11223344, 4'hF, 0, 0);
    txn(1, 1, 0, 32'h200, 32'hAABBCCDD, 4'b0101, 0, 0);
    txn(1, 0, 1, 32'h200, 0, 4'h0, 0, 0);

    do_reset();
    txn(1, 0, 1, 32'h200, 0, 4'h0, 1, 32'h100);
    txn(1, 0, 1, 32'h010, 0, 4'h0, 1, 32'h104);

    txn(1, 1, 0, 32'h000, 32'h5A5A0001, 4'hF, 0, 0);
    txn(0, 0, 0, 0, 0, 4'h0, 1, 32'h1000);
    txn(0, 0, 0, 0, 0, 4'h0, 1, 32'h103);

    // Abort a read in BUSY with reset: no pulse may follow, outputs cleared.
    @(negedge clk);
    mem_address = 32'h100; mem_read = 1'b1;
    @(negedge clk);
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    chk("abort_mem_rdata", mem_rdata, 32'h0);
    chk("abort_instr", instr, 32'h0);
    @(negedge clk);
    rst = 1'b0; prefer_data = 1'b1; last_rdata = '0;
    seen = 0;
    for (int n = 0; n < L + 4; n++) begin
      @(negedge clk);
      if (mem_resp || imem_resp) seen = 1;
    end
    chk("abort_no_resp", {31'b0, seen}, 32'h0);
    txn(1, 0, 1, 32'h100, 0, 4'h0, 0, 0);

    txn(1, 1, 1, 32'h008, 32'hCAFEF00D, 4'hF, 0, 0);
    txn(1, 0, 1, 32'h008, 0, 4'h0, 0, 0);
    txn(1, 1, 0, 32'h00C, 32'hFFFFFFFF, 4'h0, 0, 0);
    txn(1, 0, 1, 32'h00C, 0, 4'h0, 0, 0);

    for (int t = 0; t < 80; t++) begin
      int          kind, op;
      logic [31:0] da, fa;
      kind = $urandom_range(0, 2);
      op   = $urandom_range(0, 2);
      da   = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      fa   = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      txn(kind != 1, op != 0, op != 1, da, $urandom, 4'($urandom_range(0, 15)), kind != 0, fa);
    end

    // LATENCY=1 instance: preload words, then fetch them continuously.
    for (int i = 0; i < 8; i++) begin
      fw[i] = $urandom;
      @(negedge clk);
      f_mem_write = 1; f_mem_address = 32'(i*4); f_mem_wdata = fw[i]; f_mem_byte_enable = 4'hF;
      done = 0;
      for (int n = 0; n < 10 && !done; n++) begin
        @(negedge clk);
        if (f_mem_resp) done = 1;
      end
      f_mem_write = 0;
      if (!done) begin
        checks++; failures++;
        $display("FAIL fast_write_timeout actual=no resp required=resp");
      end
    end
    @(negedge clk);
    f_pc = 0; f_imem_read = 1;
    k = 0; last = 0;
    for (int n = 0; n < 40 && k < 8; n++) begin
      @(negedge clk);
      if (f_imem_resp) begin
        chk("fast_instr", f_instr, fw[k]);
        if (k > 0) chk("fast_spacing", 32'(cyc - last), 32'd2);
        last = cyc;
        k++;
        f_pc = 32'(k*4);
      end
    end
    f_imem_read = 0;
    chk("fast_fetch_count", 32'(k), 32'd8);

    repeat (3) @(negedge clk);
    if (dq.size() != 0 || fq.size() != 0) begin
      checks++; failures++;
      $display("FAIL leftover_expectations actual=%0d required=0", dq.size() + fq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
